// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Types and constants shared by the instruction fetch stage.
//   - fetch_state_t : fetch sequencer states
//   - NOP_INSTR     : word presented to the decoder before the first fetch
//   - PC_W          : architectural PC / instruction word width
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned PC_W = 32;

  // addi x0, x0, 0
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // not fetching; waits for run
    REQ    = 3'd1,  // memory read outstanding
    DRAIN  = 3'd2,  // redirected mid-read; waiting to discard the old word
    DECODE = 3'd3,  // decode strobe cycle
    WAIT   = 3'd4,  // waiting for the decoder to complete and downstream to consume
    HALT   = 3'd5   // misaligned redirect seen; left only through reset
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   Architectural PC register. A redirect load has priority over the
//   sequential increment. pc_next is the value the PC takes at the next edge;
//   the sequencer uses it to launch a read in the same cycle the PC changes.
// Ports
//   clk, rst  : clock, asynchronous active-high reset (pc <= RESET_PC)
//   load      : take load_pc at the next edge
//   load_pc   : redirect target
//   inc       : advance by PC_STEP (modulo 2^32) when not loading
//   pc        : current PC
//   pc_next   : PC after the next edge
// -----------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_pc;
    end else if (inc) begin
      pc_next = pc + PC_STEP;   // natural 32-bit wrap
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Reads 32-bit words from instruction memory over a
//   req/ack handshake, presents them with their PC to the decoder and pulses
//   dec_enabled for one cycle, then waits for dec_completed && advance before
//   fetching the next word. Redirects from execute replace the PC; a read that
//   is already outstanding is always allowed to finish and its data dropped.
//
// Configuration
//   FETCH_MISALIGN_CHECK_EN  defined  : a redirect_pc with [1:0]!=0 sets the
//                                       sticky misalign_err and parks the unit
//                                       in HALT (after draining any open read).
//                            undefined: redirect_pc[1:0] is forced to 2'b00,
//                                       misalign_err is tied low.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   run             : fetching permitted (looked at in IDLE and on WAIT exit)
//   redirect_valid  : one-cycle redirect pulse
//   redirect_pc     : redirect target
//   imem_req        : read request, held until imem_ack
//   imem_addr       : read address, stable while imem_req is high
//   imem_ack        : read complete, imem_rdata valid this cycle
//   imem_rdata      : instruction word
//   dec_enabled     : one-cycle decode strobe
//   dec_pc          : PC of the presented instruction
//   dec_instr_raw   : presented instruction word
//   dec_completed   : decoder completed level (low during the strobe cycle)
//   advance         : downstream has consumed the decoded instruction
//   misalign_err    : sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            dec_enabled,
  output logic [PC_W-1:0] dec_pc,
  output logic [PC_W-1:0] dec_instr_raw,
  input  logic            dec_completed,
  input  logic            advance,
  output logic            misalign_err
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] redirect_target;
  logic            bad_redirect;   // misaligned redirect that must halt the unit
  logic            halt_pending;   // misaligned redirect seen while draining
  logic            pc_load;
  logic            pc_inc;
  logic            wait_exit;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign bad_redirect    = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != HALT);

  logic misalign_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (bad_redirect) begin
      misalign_q <= 1'b1;
    end
  end
  assign misalign_err = misalign_q;
`else
  // Low address bits are dropped, so a misaligned target fetches its word.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};
  assign bad_redirect    = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  assign wait_exit = dec_completed && advance;

  // A redirect replaces the PC in every live state, including REQ and DRAIN,
  // where the outstanding read keeps its old address on imem_addr. A redirect
  // in WAIT suppresses the increment, so a same-cycle advance is ignored.
  assign pc_load = redirect_valid && !bad_redirect && (state != HALT);
  assign pc_inc  = (state == WAIT) && wait_exit && !redirect_valid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (redirect_target),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_next (pc_next)
  );

  // Sequencer. All outputs are registered; a read is launched with
  // imem_addr <= pc_next so a redirect or increment taken in the same cycle
  // is already reflected in the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      dec_enabled   <= 1'b0;
      dec_pc        <= '0;
      dec_instr_raw <= NOP_INSTR;
      halt_pending  <= 1'b0;
    end else begin
      dec_enabled <= 1'b0;   // strobe is high only in the cycle after an accepted word

      case (state)
        IDLE: begin
          if (bad_redirect) begin
            state <= HALT;
          end else if (run) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_next;
          end
        end

        REQ: begin
          if (imem_ack) begin
            if (bad_redirect) begin
              state    <= HALT;
              imem_req <= 1'b0;
            end else if (redirect_valid) begin
              // Word belongs to the old path: drop it and fetch the target.
              // The acked read is complete, so the address may move now.
              imem_addr <= pc_next;
            end else begin
              state         <= DECODE;
              imem_req      <= 1'b0;
              dec_enabled   <= 1'b1;
              dec_pc        <= pc;
              dec_instr_raw <= imem_rdata;
            end
          end else if (redirect_valid) begin
            // The memory has already seen the request; let it finish.
            state        <= DRAIN;
            halt_pending <= bad_redirect;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            if (halt_pending || bad_redirect) begin
              state    <= HALT;
              imem_req <= 1'b0;
            end else begin
              state     <= REQ;
              imem_addr <= pc_next;   // latest redirect wins
            end
          end else if (bad_redirect) begin
            halt_pending <= 1'b1;
          end
        end

        DECODE: begin
          // The strobe has already fired; on a redirect the consumer squashes
          // it and there is no completion to wait for.
          if (bad_redirect) begin
            state <= HALT;
          end else if (redirect_valid) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (bad_redirect) begin
            state <= HALT;
          end else if (redirect_valid || wait_exit) begin
            if (run) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_next;
            end else begin
              state <= IDLE;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A behavioural memory acks after mem_lat
//   cycles with word mem_word(addr); the decoder/consumer side is a simple
//   level model enabled by cons_en. Monitors log every acked read and every
//   decode strobe; each test task checks those logs against hand-computed
//   values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        dec_enabled;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr_raw;
  logic        dec_completed;
  logic        advance;
  logic        misalign_err;

  logic        cons_en;
  int          mem_lat;
  int          n_cmp = 0;
  int          n_err = 0;
  int          addr_changes = 0;
  int          wait_cnt = 0;
  logic [31:0] held_addr = 32'h0;

  logic [31:0] s_pc[$];
  logic [31:0] s_instr[$];
  logic [31:0] a_addr[$];
  int          a_hold[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dec_enabled    (dec_enabled),
    .dec_pc         (dec_pc),
    .dec_instr_raw  (dec_instr_raw),
    .dec_completed  (dec_completed),
    .advance        (advance),
    .misalign_err   (misalign_err)
  );

  // Consumer: completes every cycle except the strobe cycle.
  assign dec_completed = cons_en & ~dec_enabled;
  assign advance       = cons_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: ack in the mem_lat-th cycle of a request; log address and hold time.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt > 0 && imem_addr !== held_addr) addr_changes++;
      held_addr = imem_addr;
      if (wait_cnt + 1 >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        a_addr.push_back(imem_addr);
        a_hold.push_back(wait_cnt + 1);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (dec_enabled) begin
      s_pc.push_back(dec_pc);
      s_instr.push_back(dec_instr_raw);
    end
  end

  task automatic apply_reset();
    rst            = 1'b1;
    run            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cons_en        = 1'b0;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) until n strobes have been logged since base; returns #1
  // after a posedge.
  task automatic wait_strobes(input int base, input int n, input int budget, input string what);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (s_pc.size() < base + n && k < budget);
    n_cmp++;
    if (s_pc.size() < base + n) begin
      n_err++;
      $display("FAIL %s timeout: strobes got %0d want %0d", what, s_pc.size() - base, n);
    end
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    run            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cons_en        = 1'b0;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++; if (dec_enabled !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", dec_enabled); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_err++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
    n_cmp++; if (dec_instr_raw !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h want 00000013", dec_instr_raw); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    int bs, ba;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size();
    cons_en = 1'b1; run = 1'b1;
    wait_strobes(bs, 3, 60, "seq");
    run = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (s_pc.size() - bs !== 3) begin n_err++; $display("FAIL seq_count: got %0d want 3", s_pc.size() - bs); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_a;
      exp_a = 32'(4 * i);
      n_cmp++;
      if (s_pc.size() <= bs + i || s_pc[bs+i] !== exp_a) begin
        n_err++; $display("FAIL seq_dec_pc[%0d]: got %h want %h", i, (s_pc.size() > bs + i) ? s_pc[bs+i] : 32'hx, exp_a);
      end
      n_cmp++;
      if (s_instr.size() <= bs + i || s_instr[bs+i] !== mem_word(exp_a)) begin
        n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", i, (s_instr.size() > bs + i) ? s_instr[bs+i] : 32'hx, mem_word(exp_a));
      end
      n_cmp++;
      if (a_addr.size() <= ba + i || a_addr[ba+i] !== exp_a) begin
        n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, (a_addr.size() > ba + i) ? a_addr[ba+i] : 32'hx, exp_a);
      end
    end
  endtask

  task automatic test_latency();
    int bs, ba, bc;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size(); bc = addr_changes;
    mem_lat = 3; cons_en = 1'b1; run = 1'b1;
    wait_strobes(bs, 1, 40, "lat");
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (a_addr.size() - ba !== 1) begin n_err++; $display("FAIL lat_reads: got %0d want 1", a_addr.size() - ba); end
    n_cmp++; if (a_hold.size() <= ba || a_hold[ba] !== 3) begin n_err++; $display("FAIL lat_hold: got %0d want 3", (a_hold.size() > ba) ? a_hold[ba] : -1); end
    n_cmp++; if (addr_changes !== bc) begin n_err++; $display("FAIL lat_addr_stable: got %0d changes want 0", addr_changes - bc); end
    n_cmp++; if (dec_instr_raw !== mem_word(32'h0)) begin n_err++; $display("FAIL lat_instr: got %h want %h", dec_instr_raw, mem_word(32'h0)); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_err++; $display("FAIL lat_dec_pc: got %h want 0", dec_pc); end
  endtask

  task automatic test_redirect_wait();
    int bs, ba;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size();
    run = 1'b1;
    wait_strobes(bs, 1, 20, "rdw_first");
    repeat (2) @(posedge clk);   // parked in WAIT: consumer disabled
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; cons_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_strobes(bs, 2, 20, "rdw_second");
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (a_addr.size() - ba !== 2) begin n_err++; $display("FAIL rdw_reads: got %0d want 2", a_addr.size() - ba); end
    n_cmp++; if (a_addr.size() <= ba + 1 || a_addr[ba+1] !== 32'h100) begin n_err++; $display("FAIL rdw_addr: got %h want 00000100", (a_addr.size() > ba + 1) ? a_addr[ba+1] : 32'hx); end
    n_cmp++; if (s_pc.size() <= bs + 1 || s_pc[bs+1] !== 32'h100) begin n_err++; $display("FAIL rdw_dec_pc: got %h want 00000100", (s_pc.size() > bs + 1) ? s_pc[bs+1] : 32'hx); end
  endtask

  task automatic test_redirect_req();
    int bs, ba, bc, k;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size(); bc = addr_changes;
    mem_lat = 3; cons_en = 1'b1; run = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (imem_req !== 1'b1 && k < 10);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_strobes(bs, 1, 40, "rdq");
    run = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (a_addr.size() - ba !== 2) begin n_err++; $display("FAIL rdq_reads: got %0d want 2", a_addr.size() - ba); end
    n_cmp++; if (a_addr.size() <= ba || a_addr[ba] !== 32'h0) begin n_err++; $display("FAIL rdq_old_addr: got %h want 0", (a_addr.size() > ba) ? a_addr[ba] : 32'hx); end
    n_cmp++; if (a_hold.size() <= ba || a_hold[ba] !== 3) begin n_err++; $display("FAIL rdq_old_hold: got %0d want 3", (a_hold.size() > ba) ? a_hold[ba] : -1); end
    n_cmp++; if (a_addr.size() <= ba + 1 || a_addr[ba+1] !== 32'h200) begin n_err++; $display("FAIL rdq_new_addr: got %h want 00000200", (a_addr.size() > ba + 1) ? a_addr[ba+1] : 32'hx); end
    n_cmp++; if (addr_changes !== bc) begin n_err++; $display("FAIL rdq_addr_stable: got %0d changes want 0", addr_changes - bc); end
    n_cmp++; if (s_pc.size() - bs !== 1) begin n_err++; $display("FAIL rdq_strobes: got %0d want 1", s_pc.size() - bs); end
    n_cmp++; if (s_pc.size() <= bs || s_pc[bs] !== 32'h200) begin n_err++; $display("FAIL rdq_dec_pc: got %h want 00000200", (s_pc.size() > bs) ? s_pc[bs] : 32'hx); end
    n_cmp++; if (s_instr.size() <= bs || s_instr[bs] !== mem_word(32'h200)) begin n_err++; $display("FAIL rdq_instr: got %h want %h", (s_instr.size() > bs) ? s_instr[bs] : 32'hx, mem_word(32'h200)); end
  endtask

  task automatic test_redirect_ack();
    int bs, ba, k;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size();
    cons_en = 1'b1; run = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (imem_req !== 1'b1 && k < 10);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_strobes(bs, 1, 20, "rda");
    run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (a_addr.size() - ba !== 2) begin n_err++; $display("FAIL rda_reads: got %0d want 2", a_addr.size() - ba); end
    n_cmp++; if (a_addr.size() <= ba + 1 || a_addr[ba+1] !== 32'h300) begin n_err++; $display("FAIL rda_new_addr: got %h want 00000300", (a_addr.size() > ba + 1) ? a_addr[ba+1] : 32'hx); end
    n_cmp++; if (s_pc.size() - bs !== 1) begin n_err++; $display("FAIL rda_strobes: got %0d want 1", s_pc.size() - bs); end
    n_cmp++; if (s_instr.size() <= bs || s_instr[bs] !== mem_word(32'h300)) begin n_err++; $display("FAIL rda_instr: got %h want %h", (s_instr.size() > bs) ? s_instr[bs] : 32'hx, mem_word(32'h300)); end
  endtask

  task automatic test_wrap();
    int bs, ba;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; cons_en = 1'b1; run = 1'b1;
    wait_strobes(bs, 2, 30, "wrap");
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (s_pc.size() <= bs || s_pc[bs] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_pc: got %h want fffffffc", (s_pc.size() > bs) ? s_pc[bs] : 32'hx); end
    n_cmp++; if (s_pc.size() <= bs + 1 || s_pc[bs+1] !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc: got %h want 0", (s_pc.size() > bs + 1) ? s_pc[bs+1] : 32'hx); end
    n_cmp++; if (a_addr.size() <= ba + 1 || a_addr[ba+1] !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", (a_addr.size() > ba + 1) ? a_addr[ba+1] : 32'hx); end
  endtask

  task automatic test_misalign();
    int bs, ba;
    apply_reset();
    bs = s_pc.size(); ba = a_addr.size();
    cons_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", misalign_err); end
    run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", imem_req); end
    n_cmp++; if (a_addr.size() - ba !== 0) begin n_err++; $display("FAIL mis_reads: got %0d want 0", a_addr.size() - ba); end
    n_cmp++; if (s_pc.size() - bs !== 0) begin n_err++; $display("FAIL mis_strobes: got %0d want 0", s_pc.size() - bs); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky: got %b want 1", misalign_err); end
    run = 1'b0;
`else
    run = 1'b1;
    wait_strobes(bs, 1, 20, "mis");
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (a_addr.size() <= ba || a_addr[ba] !== 32'h100) begin n_err++; $display("FAIL mis_addr: got %h want 00000100", (a_addr.size() > ba) ? a_addr[ba] : 32'hx); end
    n_cmp++; if (s_pc.size() <= bs || s_pc[bs] !== 32'h100) begin n_err++; $display("FAIL mis_dec_pc: got %h want 00000100", (s_pc.size() > bs) ? s_pc[bs] : 32'hx); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_flag: got %b want 0", misalign_err); end
`endif
  endtask

  task automatic test_async_reset();
    int bs;
    apply_reset();
    bs = s_pc.size();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0; cons_en = 1'b1; run = 1'b1;
    wait_strobes(bs, 1, 20, "arst");
    mem_lat = 8;   // next read (0x44) stays open
    @(posedge clk);
    #2;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin n_err++; $display("FAIL arst_open_req: got req=%b addr=%h want req=1 addr=00000044", imem_req, imem_addr); end
    n_cmp++; if (dec_pc !== 32'h40) begin n_err++; $display("FAIL arst_pre_dec_pc: got %h want 00000040", dec_pc); end
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL arst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL arst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_err++; $display("FAIL arst_dec_pc: got %h want 0", dec_pc); end
    n_cmp++; if (dec_instr_raw !== 32'h0000_0013) begin n_err++; $display("FAIL arst_instr: got %h want 00000013", dec_instr_raw); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_ack();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
